// File: rtl/new_usb_listfetch.sv
// OHCI list walker: picks the active list (periodic/control/bulk) and issues one tagged DMA read
// per descriptor, following next-addresses returned by the descriptor unpacker.
module new_usb_listfetch #(
  parameter int unsigned MaxFlying = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [2:0]  list_en_i,
  input  logic [27:0] periodic_head_i,
  input  logic [27:0] control_head_i,
  input  logic [27:0] bulk_head_i,
  input  logic        frame_start_i,
  input  logic        counter_is_threshold_i,
  input  logic        nextis_valid_i,
  input  logic        nextis_ed_i,
  input  logic [1:0]  nextis_type_i,
  input  logic [27:0] nextis_address_i,
  output logic        nextis_ready_o,
  output logic        dma_req_valid_o,
  input  logic        dma_req_ready_i,
  output logic [31:0] dma_req_addr_o,
  output logic [5:0]  dma_req_len_o,
  input  logic        dma_done_i,
  output logic        id_valid_o,
  output logic [2:0]  id_type_o,
  output logic        sent_head_o,
  output logic        context_switch_np2p_o,
  output logic        context_switch_p2np_o
);

  typedef enum logic [1:0] {StIdle, StPeriodic, StNonperiodic} state_e;

  localparam logic [1:0] ChControl   = 2'b00;
  localparam logic [1:0] ChBulk      = 2'b01;
  localparam logic [1:0] ChInterrupt = 2'b10;
  localparam logic [1:0] ChIso       = 2'b11;
  localparam logic [1:0] MaxFly      = 2'(MaxFlying);

  state_e      r_state, w_state_d;
  logic        r_req_valid, w_req_valid_d;
  logic [27:0] r_req_addr, w_req_addr_d;
  logic        r_req_ed, w_req_ed_d;
  logic [1:0]  r_req_type, w_req_type_d;
  logic        r_req_head, w_req_head_d;
  logic [1:0]  r_flying, w_flying_d;
  logic        r_need_head, w_need_head_d;
  logic        r_need_res, w_need_res_d;
  logic        r_fs_pend, w_fs_pend_d;
  logic        r_res_valid, w_res_valid_d;
  logic [27:0] r_res_addr, w_res_addr_d;
  logic        r_res_ed, w_res_ed_d;
  logic [1:0]  r_res_type, w_res_type_d;
  logic        r_np2p, w_np2p_d;
  logic        r_p2np, w_p2np_d;

  logic        w_hs, w_nx, w_nx_ready, w_below_max, w_can_load, w_nx_zero;
  logic        w_ctrl_ok, w_bulk_ok, w_per_ok, w_pick_ctrl;
  logic        w_ld, w_ld_ed, w_ld_head;
  logic [27:0] w_ld_addr;
  logic [1:0]  w_ld_type;

  assign w_hs        = r_req_valid && dma_req_ready_i;
  assign w_below_max = r_flying < MaxFly;
  assign w_can_load  = !r_req_valid && w_below_max;
  assign w_nx_ready  = (r_state != StIdle) && !r_req_valid && w_below_max && !frame_start_i &&
                       !r_fs_pend && !r_need_head && !r_need_res;
  assign w_nx        = nextis_valid_i && w_nx_ready;
  assign w_nx_zero   = nextis_address_i == '0;

  assign w_ctrl_ok   = list_en_i[0] && (control_head_i != '0);
  assign w_bulk_ok   = list_en_i[1] && (bulk_head_i != '0);
  assign w_per_ok    = list_en_i[2] && (periodic_head_i != '0);
  // Threshold only diverts to bulk when bulk is actually servable.
  assign w_pick_ctrl = (w_ctrl_ok && !counter_is_threshold_i) || (w_ctrl_ok && !w_bulk_ok);

  always_comb begin
    w_state_d     = r_state;
    w_req_valid_d = r_req_valid;
    w_req_addr_d  = r_req_addr;
    w_req_ed_d    = r_req_ed;
    w_req_type_d  = r_req_type;
    w_req_head_d  = r_req_head;
    w_need_head_d = r_need_head;
    w_need_res_d  = r_need_res;
    w_fs_pend_d   = r_fs_pend;
    w_res_valid_d = r_res_valid;
    w_res_addr_d  = r_res_addr;
    w_res_ed_d    = r_res_ed;
    w_res_type_d  = r_res_type;
    w_np2p_d      = 1'b0;
    w_p2np_d      = 1'b0;
    w_ld          = 1'b0;
    w_ld_addr     = '0;
    w_ld_ed       = 1'b0;
    w_ld_type     = ChControl;
    w_ld_head     = 1'b0;

    if (w_hs) begin
      w_req_valid_d = 1'b0;
      // The last nonperiodic request issued is where a periodic interruption resumes.
      if (r_state == StNonperiodic) begin
        w_res_valid_d = 1'b1;
        w_res_addr_d  = r_req_addr;
        w_res_ed_d    = r_req_ed;
        w_res_type_d  = r_req_type;
      end
    end
    if (frame_start_i && r_req_valid && (r_state == StNonperiodic)) w_fs_pend_d = 1'b1;

    unique case (r_state)
      StIdle: begin
        if (frame_start_i) begin
          w_need_head_d = 1'b1;
          w_need_res_d  = 1'b0;
          w_state_d     = w_per_ok ? StPeriodic : StNonperiodic;
        end
      end
      StPeriodic: begin
        if (w_nx) begin
          if (w_nx_zero) begin
            if (nextis_ed_i) begin
              w_p2np_d      = 1'b1;
              w_state_d     = StNonperiodic;
              w_need_res_d  = r_res_valid;
              w_need_head_d = !r_res_valid;
            end
          end else begin
            w_ld      = 1'b1;
            w_ld_addr = nextis_address_i;
            w_ld_ed   = nextis_ed_i;
            w_ld_type = nextis_type_i;
          end
        end else if (r_need_head && w_can_load) begin
          w_need_head_d = 1'b0;
          w_ld          = 1'b1;
          w_ld_addr     = periodic_head_i;
          w_ld_ed       = 1'b1;
          w_ld_type     = ChInterrupt;
          w_ld_head     = 1'b1;
        end
      end
      StNonperiodic: begin
        if ((frame_start_i || r_fs_pend) && !r_req_valid) begin
          w_fs_pend_d = 1'b0;
          if (w_per_ok) begin
            w_np2p_d      = 1'b1;
            w_state_d     = StPeriodic;
            w_need_head_d = 1'b1;
            w_need_res_d  = 1'b0;
          end
        end else if (w_nx) begin
          if (w_nx_zero) begin
            if (nextis_ed_i) begin
              w_need_head_d = 1'b1;
              w_res_valid_d = 1'b0;
            end
          end else begin
            w_ld      = 1'b1;
            w_ld_addr = nextis_address_i;
            w_ld_ed   = nextis_ed_i;
            w_ld_type = nextis_type_i;
          end
        end else if (w_can_load) begin
          if (r_need_res) begin
            w_need_res_d = 1'b0;
            w_ld         = 1'b1;
            w_ld_addr    = r_res_addr;
            w_ld_ed      = r_res_ed;
            w_ld_type    = r_res_type;
          end else if (r_need_head) begin
            w_need_head_d = 1'b0;
            if (w_ctrl_ok || w_bulk_ok) begin
              w_ld      = 1'b1;
              w_ld_addr = w_pick_ctrl ? control_head_i : bulk_head_i;
              w_ld_ed   = 1'b1;
              w_ld_type = w_pick_ctrl ? ChControl : ChBulk;
              w_ld_head = 1'b1;
            end else begin
              w_state_d     = StIdle;
              w_res_valid_d = 1'b0;
            end
          end
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_ld) begin
      w_req_valid_d = 1'b1;
      w_req_addr_d  = w_ld_addr;
      w_req_ed_d    = w_ld_ed;
      w_req_type_d  = w_ld_type;
      w_req_head_d  = w_ld_head;
    end
  end

  always_comb begin
    unique case ({w_hs, dma_done_i})
      2'b10:   w_flying_d = r_flying + 2'd1;
      2'b01:   w_flying_d = r_flying - 2'd1;
      default: w_flying_d = r_flying;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_ed    <= 1'b0;
      r_req_type  <= ChControl;
      r_req_head  <= 1'b0;
      r_flying    <= '0;
      r_need_head <= 1'b0;
      r_need_res  <= 1'b0;
      r_fs_pend   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_addr  <= '0;
      r_res_ed    <= 1'b0;
      r_res_type  <= ChControl;
      r_np2p      <= 1'b0;
      r_p2np      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_req_valid <= w_req_valid_d;
      r_req_addr  <= w_req_addr_d;
      r_req_ed    <= w_req_ed_d;
      r_req_type  <= w_req_type_d;
      r_req_head  <= w_req_head_d;
      r_flying    <= w_flying_d;
      r_need_head <= w_need_head_d;
      r_need_res  <= w_need_res_d;
      r_fs_pend   <= w_fs_pend_d;
      r_res_valid <= w_res_valid_d;
      r_res_addr  <= w_res_addr_d;
      r_res_ed    <= w_res_ed_d;
      r_res_type  <= w_res_type_d;
      r_np2p      <= w_np2p_d;
      r_p2np      <= w_p2np_d;
    end
  end

  assign nextis_ready_o        = w_nx_ready;
  assign dma_req_valid_o       = r_req_valid;
  assign dma_req_addr_o        = {r_req_addr, 4'b0000};
  assign dma_req_len_o         = !r_req_valid ? 6'd0 :
                                 (!r_req_ed && (r_req_type == ChIso)) ? 6'd32 : 6'd16;
  assign id_valid_o            = w_hs;
  assign id_type_o             = w_hs ? {r_req_ed, r_req_type} : 3'b000;
  assign sent_head_o           = w_hs && r_req_head;
  assign context_switch_np2p_o = r_np2p;
  assign context_switch_p2np_o = r_p2np;

  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(dma_done_i && !w_hs && (r_flying == 2'd0)));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   !(w_hs && !dma_done_i && (r_flying == 2'd3)));

endmodule

// File: tb/tb_new_usb_listfetch.sv
// Scoreboard bench for new_usb_listfetch: the stimulus side plays the unpacker and pushes the
// requests the list rules predict; a monitor pops them at every DMA request handshake.
module tb_new_usb_listfetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  list_en;
  logic [27:0] per_head, ctl_head, blk_head;
  logic        frame_start, thr;
  logic        nextis_valid, nextis_ed, nextis_ready;
  logic [1:0]  nextis_type;
  logic [27:0] nextis_addr;
  logic        req_valid, req_ready, dma_done;
  logic [31:0] req_addr;
  logic [5:0]  req_len;
  logic        id_valid, sent_head, np2p, p2np;
  logic [2:0]  id_type;

  always #5 clk = ~clk;

  new_usb_listfetch #(.MaxFlying(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .list_en_i(list_en), .periodic_head_i(per_head),
    .control_head_i(ctl_head), .bulk_head_i(blk_head), .frame_start_i(frame_start),
    .counter_is_threshold_i(thr), .nextis_valid_i(nextis_valid), .nextis_ed_i(nextis_ed),
    .nextis_type_i(nextis_type), .nextis_address_i(nextis_addr), .nextis_ready_o(nextis_ready),
    .dma_req_valid_o(req_valid), .dma_req_ready_i(req_ready), .dma_req_addr_o(req_addr),
    .dma_req_len_o(req_len), .dma_done_i(dma_done), .id_valid_o(id_valid), .id_type_o(id_type),
    .sent_head_o(sent_head), .context_switch_np2p_o(np2p), .context_switch_p2np_o(p2np)
  );

  typedef struct {
    logic [31:0] addr;
    logic [5:0]  len;
    logic [2:0]  id;
    logic        head;
  } req_t;

  req_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   hs_cnt = 0, done_cnt = 0, np2p_cnt = 0, p2np_cnt = 0;
  bit   auto_ready = 1'b1, ready_force = 1'b0, auto_done = 1'b1, done_force = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference rules: byte address, length by descriptor kind, ID tag.
  task automatic push(input logic [27:0] a, input logic ed, input logic [1:0] ty, input logic hd);
    req_t e;
    e.addr = {a, 4'h0};
    e.len  = (!ed && ty == 2'b11) ? 6'd32 : 6'd16;
    e.id   = {ed, ty};
    e.head = hd;
    exp_q.push_back(e);
  endtask

  // Nonperiodic list choice at list end / list start.
  function automatic bit pick(output logic [27:0] a, output logic [1:0] ty);
    a = '0; ty = 2'b00;
    if (list_en[0] && !thr && ctl_head != 0) begin a = ctl_head; ty = 2'b00; return 1'b1; end
    if (list_en[1] && blk_head != 0) begin a = blk_head; ty = 2'b01; return 1'b1; end
    if (list_en[0] && ctl_head != 0) begin a = ctl_head; ty = 2'b00; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic logic [27:0] rnd28();
    logic [27:0] v;
    do v = 28'($urandom); while (v == 0);
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (np2p) np2p_cnt++;
      if (p2np) p2np_cnt++;
      if (req_valid && req_ready) begin
        hs_cnt++;
        check("id_valid_at_hs", id_valid, 1);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_req: got addr 0x%0h id %0b, expected none", req_addr, id_type);
        end else begin
          req_t e;
          e = exp_q.pop_front();
          check("req_addr", req_addr, e.addr);
          check("req_len", req_len, e.len);
          check("id_type", id_type, e.id);
          check("sent_head", sent_head, e.head);
        end
      end else begin
        check("no_id_without_hs", {id_valid, sent_head}, 0);
      end
    end
  end

  initial begin
    req_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      req_ready = auto_ready ? ($urandom_range(3) != 0) : ready_force;
    end
  end

  initial begin
    dma_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (auto_done) dma_done = (done_cnt < hs_cnt) && ($urandom_range(1) == 1);
      else dma_done = done_force;
      if (dma_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic fs();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic send(input logic ed, input logic [1:0] ty, input logic [27:0] a);
    bit acc = 1'b0;
    int n = 0;
    nextis_valid = 1'b1; nextis_ed = ed; nextis_type = ty; nextis_addr = a;
    while (!acc && n < 300) begin
      @(negedge clk); acc = nextis_ready; tick(); n++;
    end
    nextis_valid = 1'b0;
    check("nextis_accept_timeout", acc, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || (auto_done && done_cnt != hs_cnt)) && n < 500) begin
      tick(); n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    logic [46:0] outs;
    logic [27:0] a, x, y, p, e2;
    logic [1:0]  t;
    int h0;
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [46:0] outs;
    logic [27:0] a, x, y, p, e2, ch;
    logic [1:0]  t;
    int h0, r;
    rst_n = 1'b0; list_en = 3'b000; per_head = '0; ctl_head = '0; blk_head = '0;
    frame_start = 1'b0; thr = 1'b0; nextis_valid = 1'b0; nextis_ed = 1'b0;
    nextis_type = 2'b00; nextis_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {req_valid, req_addr, req_len, id_valid, id_type, sent_head, np2p, p2np, nextis_ready};
    check("reset_outputs", outs, 0);
    tick(); rst_n = 1'b1; tick();

    // Control list head, TDs, ISO TD length, empty-TD ED, list end.
    ch = 28'h0000100; list_en = 3'b001; ctl_head = ch; blk_head = rnd28();
    push(ch, 1, 2'b00, 1); fs(); drain();
    a = rnd28(); push(a, 0, 2'b00, 0); send(0, 2'b00, a); drain();
    push(28'h0000340, 0, 2'b11, 0); send(0, 2'b11, 28'h0000340); drain();
    send(0, 2'b00, 28'h0);
    a = rnd28(); push(a, 1, 2'b00, 0); send(1, 2'b00, a); drain();
    push(ch, 1, 2'b00, 1); send(1, 2'b00, 28'h0); drain();

    // Threshold diverts to bulk at list end.
    list_en = 3'b011; blk_head = 28'h0000600; thr = 1'b1;
    push(blk_head, 1, 2'b01, 1); send(1, 2'b00, 28'h0); drain();
    x = 28'h0000500; push(x, 1, 2'b01, 0); send(1, 2'b01, x); drain();

    // Frame start beats a waiting next-address; periodic run then resume at the bulk ED.
    list_en = 3'b111; p = 28'h0000200; per_head = p; thr = 1'b0;
    nextis_valid = 1'b1; nextis_ed = 1'b0; nextis_type = 2'b01; nextis_addr = rnd28();
    frame_start = 1'b1;
    @(negedge clk); check("fs_blocks_nextis", nextis_ready, 0);
    tick(); frame_start = 1'b0; nextis_valid = 1'b0;
    push(p, 1, 2'b10, 1); drain();
    check("np2p_pulses", np2p_cnt, 1);
    a = rnd28(); push(a, 1, 2'b10, 0); send(1, 2'b10, a); drain();
    push(x, 1, 2'b01, 0); send(1, 2'b10, 28'h0); drain();
    check("p2np_pulses", p2np_cnt, 1);

    // Frame start while a request is pending: request first, then the switch.
    auto_ready = 1'b0; ready_force = 1'b0;
    y = rnd28(); push(y, 1, 2'b00, 0); send(1, 2'b00, y);
    fs(); tick(); tick();
    check("np2p_deferred", np2p_cnt, 1);
    auto_ready = 1'b1;
    push(p, 1, 2'b10, 1); drain();
    check("np2p_after_pending", np2p_cnt, 2);
    push(y, 1, 2'b00, 0); send(1, 2'b10, 28'h0); drain();
    check("p2np_second", p2np_cnt, 2);

    // One read in flight: next address held until the completion.
    auto_done = 1'b0;
    a = rnd28(); push(a, 1, 2'b00, 0); send(1, 2'b00, a); drain();
    e2 = rnd28();
    nextis_valid = 1'b1; nextis_ed = 1'b1; nextis_type = 2'b00; nextis_addr = e2;
    repeat (4) begin
      @(negedge clk); check("held_at_limit", nextis_ready, 0); tick();
    end
    done_force = 1'b1; tick(); done_force = 1'b0;
    push(e2, 1, 2'b00, 0); send(1, 2'b00, e2); drain();
    auto_done = 1'b1; drain();

    // No eligible list: idle until next frame start.
    list_en = 3'b000; h0 = hs_cnt;
    send(1, 2'b00, 28'h0);
    repeat (10) tick();
    check("idle_no_request", hs_cnt, h0);
    @(negedge clk); check("idle_not_ready", nextis_ready, 0); tick();
    list_en = 3'b010;
    push(blk_head, 1, 2'b01, 1); fs(); drain();

    // Random walk through nonperiodic lists.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(9);
      if (r < 6) begin
        a = rnd28(); t = 2'($urandom); r = $urandom_range(1);
        push(a, r[0], t, 0); send(r[0], t, a); drain();
      end else if (r < 8) begin
        list_en = {1'b0, 2'($urandom)}; thr = 1'($urandom);
        ctl_head = ($urandom_range(3) == 0) ? 28'h0 : rnd28();
        blk_head = ($urandom_range(3) == 0) ? 28'h0 : rnd28();
        if (pick(a, t)) begin
          push(a, 1, t, 1); send(1, 2'b01, 28'h0); drain();
        end else begin
          send(1, 2'b01, 28'h0); repeat (4) tick();
          list_en = 3'b011; ctl_head = rnd28(); blk_head = rnd28();
          if (pick(a, t)) push(a, 1, t, 1);
          fs(); drain();
        end
      end else begin
        send(0, 2'b00, 28'h0);
      end
    end

    // Asynchronous reset with a request pending.
    auto_ready = 1'b0; ready_force = 1'b0; thr = 1'b0;
    a = rnd28(); send(1, 2'b00, a);
    @(negedge clk); check("pending_before_reset", req_valid, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_clears", {req_valid, req_addr, nextis_ready}, 0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
